// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer.
// Op codes are the ALU-native {s1,s0} selects. The FIFO stores each result
// together with its op code.
`timescale 1ns/1ps
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam int RESULT_W = 5;
    localparam int ENTRY_W  = RESULT_W + 2;  // {result, op}

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        CAPTURE     = 2'd2
    } state_e;

endpackage

// File: rtl/alu_result_fifo.sv
// Small synchronous FIFO that holds captured ALU results.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push_i, wdata_i write request and entry. A write is ignored when the FIFO is full,
//                   unless a pop happens on the same edge.
//   pop_i, rdata_o  pop request and head entry. A pop on an empty FIFO has no effect.
//   full_o, empty_o, count_o  occupancy status
// DEPTH must be a power of two so that the pointers wrap naturally.
`timescale 1ns/1ps
module alu_result_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // When the FIFO is full, a simultaneous pop frees the head slot, and the
    // write pointer is on that slot. So push and pop on the same edge are safe.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset. Reset clears count and pointers, so a stale
    // entry is never visible, and resetting the array would only add a reset
    // path to every flop in it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments only. Next-state
    // values are computed in always_comb and registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue and capture stage for the 4-bit combinational ALU.
// Accepts op requests, registers the operands and selects into the ALU, waits
// SETTLE cycles, then captures the ALU result into a result FIFO. A 4-bit
// accumulator holds the last non-compare result, so chained ops can use it as A.
// Ports:
//   in_valid/in_ready, in_a, in_b, in_op, in_use_acc  request side
//   alu_a, alu_b, alu_s0, alu_s1                      registered ALU inputs
//   alu_out                                           ALU result, sampled at capture
//   out_valid/out_ready, out_result, out_op           result FIFO head
//   acc                                               accumulator
`timescale 1ns/1ps
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE     = 1,  // 1..7
    parameter int FIFO_DEPTH = 2   // power of two, >= 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_a,
    input  logic [3:0]          in_b,
    input  logic [1:0]          in_op,
    input  logic                in_use_acc,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    output logic                alu_s0,
    output logic                alu_s1,
    input  logic [RESULT_W-1:0] alu_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_result,
    output logic [1:0]          out_op,
    output logic [3:0]          acc
);

    localparam logic [2:0] SETTLE_INIT = 3'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  alu_a_q, alu_a_d;
    logic [3:0]  alu_b_q, alu_b_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  acc_q, acc_d;

    logic               accept;
    logic               fifo_push, fifo_pop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

    // Only one op is in flight at a time. A free slot seen at accept therefore
    // stays free until its capture, because pops only add space.
    assign in_ready = rst_n & (state_q == IDLE) & ~fifo_full;
    assign accept   = in_valid & in_ready;

    // NOTE: every signal written in this block gets a default first. A path
    // that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        op_d      = op_q;
        acc_d     = acc_q;
        fifo_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d = in_use_acc ? acc_q : in_a;
                    alu_b_d = in_b;
                    op_d    = in_op;
                    cnt_d   = SETTLE_INIT;
                    state_d = SETTLE_WAIT;
                end
            end
            SETTLE_WAIT: begin
                if (cnt_q == 3'd0) state_d = CAPTURE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            CAPTURE: begin
                fifo_push = 1'b1;
                // Compare results are flags, not data, so they do not change the accumulator.
                if (op_q != OP_CMP) acc_d = alu_out[3:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            op_q    <= OP_ADD;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
        end
    end

    assign fifo_pop = out_ready;

    alu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({alu_out, op_q}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    logic unused_count;
    assign unused_count = ^fifo_count;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_s0     = op_q[0];
    assign alu_s1     = op_q[1];
    assign acc        = acc_q;
    assign out_valid  = ~fifo_empty;
    assign out_result = fifo_rdata[ENTRY_W-1:2];
    assign out_op     = fifo_rdata[1:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with SETTLE=1 and FIFO_DEPTH=2.
// A behavioural model of the 4-bit ALU closes the loop between alu_* and alu_out.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [3:0] in_a, in_b;
    logic [1:0] in_op;
    logic       in_use_acc;
    logic [3:0] alu_a, alu_b;
    logic       alu_s0, alu_s1;
    logic [4:0] alu_out;
    logic       out_valid, out_ready;
    logic [4:0] out_result;
    logic [1:0] out_op;
    logic [3:0] acc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // 4-bit ALU: add, subtract (carry = no borrow), compare flags, bitwise and.
    always_comb begin
        alu_out = '0;
        case ({alu_s1, alu_s0})
            OP_ADD:  alu_out = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_out = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            OP_CMP:  alu_out = {2'b00, alu_a > alu_b, alu_a == alu_b, alu_a < alu_b};
            default: alu_out = {1'b0, alu_a & alu_b};
        endcase
    end

    alu_op_sequencer #(.SETTLE(1), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_use_acc (in_use_acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s0     (alu_s0),
        .alu_s1     (alu_s1),
        .alu_out    (alu_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .acc        (acc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives a request and returns 1ns after the edge that accepts it.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic use_acc);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_use_acc = use_acc;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_use_acc = 1'b0;
    endtask

    // Counts the edges, starting after the accept edge, until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 50);
    endtask

    // Waits for a head entry, checks it, then pops it.
    task automatic expect_pop(input string tag, input logic [4:0] res, input logic [1:0] op);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"},  32'(out_valid),  32'd1);
        check({tag, "_result"}, 32'(out_result), 32'(res));
        check({tag, "_op"},     32'(out_op),     32'(op));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_use_acc = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_acc",       32'(acc),       32'd0);
        check("rst_alu_ab",    32'({alu_a, alu_b, alu_s1, alu_s0}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Add 9+8 -> 1_0001. The push edge is SETTLE+1 = 2 edges after accept.
        issue(4'h9, 4'h8, OP_ADD, 1'b0);
        wait_valid(lat);
        check("add_latency", 32'(lat), 32'd2);
        expect_pop("add98", 5'b10001, OP_ADD);
        check("add98_acc", 32'(acc), 32'h1);

        // Subtract: 3-5 borrows (carry 0), 5-3 does not.
        issue(4'h3, 4'h5, OP_SUB, 1'b0);
        expect_pop("sub35", 5'b01110, OP_SUB);
        check("sub35_acc", 32'(acc), 32'hE);
        issue(4'h5, 4'h3, OP_SUB, 1'b0);
        expect_pop("sub53", 5'b10010, OP_SUB);
        check("sub53_acc", 32'(acc), 32'h2);

        // Compare: accumulator unchanged.
        issue(4'h7, 4'h7, OP_CMP, 1'b0);
        expect_pop("cmp77", 5'b00010, OP_CMP);
        check("cmp77_acc", 32'(acc), 32'h2);
        issue(4'h2, 4'h9, OP_CMP, 1'b0);
        expect_pop("cmp29", 5'b00001, OP_CMP);
        check("cmp29_acc", 32'(acc), 32'h2);

        // Chain: 4+4 = 8, then acc & C with in_a = F ignored.
        issue(4'h4, 4'h4, OP_ADD, 1'b0);
        expect_pop("add44", 5'b01000, OP_ADD);
        issue(4'hF, 4'hC, OP_AND, 1'b1);
        check("chain_alu_a", 32'(alu_a), 32'h8);
        check("chain_alu_b", 32'(alu_b), 32'hC);
        expect_pop("and8c", 5'b01000, OP_AND);
        check("and8c_acc", 32'(acc), 32'h8);

        // Backpressure: fill both entries, hold a third request until one pop.
        issue(4'h1, 4'h1, OP_ADD, 1'b0);
        issue(4'hF, 4'h3, OP_AND, 1'b0);
        repeat (3) @(negedge clk);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        check("bp_full_ready", 32'(in_ready),  32'd0);
        in_valid = 1'b1; in_a = 4'h9; in_b = 4'h1; in_op = OP_SUB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_ready",  32'(in_ready),   32'd0);
            check("bp_hold_result", 32'(out_result), 32'b00010);
            check("bp_hold_op",     32'(out_op),     32'(OP_ADD));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_after_pop_ready", 32'(in_ready),   32'd1);
        check("bp_new_head",        32'(out_result), 32'b00011);
        @(posedge clk);
        #1 in_valid = 1'b0;
        expect_pop("bp_and", 5'b00011, OP_AND);
        expect_pop("bp_sub", 5'b11000, OP_SUB);
        check("bp_acc", 32'(acc), 32'h8);

        // Reset while an op is in SETTLE_WAIT: the op is dropped.
        issue(4'h3, 4'h3, OP_ADD, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_acc",      32'(acc),       32'd0);
        check("mid_rst_alu",      32'({alu_a, alu_b, alu_s1, alu_s0}), 32'd0);
        check("mid_rst_valid",    32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_acc",   32'(acc),       32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
